// File: rtl/dec_onehot_scan.sv
// dec_onehot_scan: registered binary-to-one-hot decoder with enable, load strobe and an
// optional free-running scan mode (digit/row select for multiplexed displays).
//
// Build option: define DEC_SCAN_MODE_EN to build the SCAN state, the prescaler and the
// wrap pulse. Without it, mode is ignored, the block acts as DIRECT whenever enable=1
// and wrap is tied low. The port list is the same in both builds.
//
// Parameters:
//   WIDTH       index width (1..6); output width is 2**WIDTH
//   DIV         scan step period in clock cycles (>= 1)
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   enable      1 = output active; 0 = output forced to zero, state frozen
//   mode        0 = direct, 1 = scan
//   load        single-cycle strobe: capture binary_in into the index
//   binary_in   index to load
//   decoder_out registered one-hot output, bit[index] set (all zero when disabled)
//   index_out   current registered index, valid in every state
//   wrap        one-cycle pulse after the scan index steps from max to 0

module dec_onehot_scan #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DIV   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    mode,
  input  logic                    load,
  input  logic [WIDTH-1:0]        binary_in,
  output logic [(2**WIDTH)-1:0]   decoder_out,
  output logic [WIDTH-1:0]        index_out,
  output logic                    wrap
);

  localparam int unsigned OutW = 2 ** WIDTH;

  typedef enum logic [1:0] {
    StIdle,
    StDirect,
    StScan
  } state_e;

  state_e           state_d;
  logic [WIDTH-1:0] index_q, index_d;
  logic [OutW-1:0]  dec_q, dec_d;

`ifdef DEC_SCAN_MODE_EN

  localparam int unsigned    PreW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(DIV - 1);
  localparam logic [WIDTH-1:0] IdxMax = '1;

  state_e          state_q;
  logic [PreW-1:0] presc_q, presc_d;
  logic            wrap_q, wrap_d;

  always_comb begin
    state_d = StIdle;
    if (enable) begin
      state_d = mode ? StScan : StDirect;
    end

    index_d = index_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;

    unique case (state_d)
      StIdle: begin
        // Everything held; load ignored.
      end
      StDirect: begin
        presc_d = '0;
        if (load) begin
          index_d = binary_in;
        end
      end
      StScan: begin
        if (load) begin
          // Load beats step, even on the terminal prescaler count.
          index_d = binary_in;
          presc_d = '0;
        end else if (state_q != StScan) begin
          // Entry edge: restart the period so the first step is DIV cycles away.
          presc_d = '0;
        end else if (presc_q == PreMax) begin
          presc_d = '0;
          index_d = index_q + 1'b1;
          wrap_d  = (index_q == IdxMax);
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: begin
      end
    endcase

    dec_d = enable ? (OutW'(1) << index_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      index_q <= '0;
      presc_q <= '0;
      wrap_q  <= 1'b0;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      presc_q <= presc_d;
      wrap_q  <= wrap_d;
      dec_q   <= dec_d;
    end
  end

  assign wrap = wrap_q;

`else

  // Scan hardware is not built: mode and DIV have no effect in this configuration.
  localparam int unsigned UnusedDiv = DIV;
  logic unused_mode;
  assign unused_mode = mode;

  always_comb begin
    state_d = enable ? StDirect : StIdle;
    index_d = index_q;

    unique case (state_d)
      StIdle: begin
      end
      StDirect: begin
        if (load) begin
          index_d = binary_in;
        end
      end
      default: begin
      end
    endcase

    dec_d = enable ? (OutW'(1) << index_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_q <= '0;
      dec_q   <= '0;
    end else begin
      index_q <= index_d;
      dec_q   <= dec_d;
    end
  end

  assign wrap = 1'b0;

`endif

  assign decoder_out = dec_q;
  assign index_out   = index_q;

endmodule

// File: tb/tb_dec_onehot_scan.sv
// Self-checking bench for dec_onehot_scan (WIDTH=4, DIV=4). Works in both builds; scan
// expectations follow whether DEC_SCAN_MODE_EN is defined for this compile.

module tb_dec_onehot_scan;

  localparam int unsigned Width = 4;
  localparam int unsigned Div   = 4;
  localparam int          N     = 1 << Width;

`ifdef DEC_SCAN_MODE_EN
  localparam bit ScanEn = 1'b1;
`else
  localparam bit ScanEn = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic             mode;
  logic             load;
  logic [Width-1:0] binary_in;
  logic [N-1:0]     decoder_out;
  logic [Width-1:0] index_out;
  logic             wrap;

  dec_onehot_scan #(
    .WIDTH (Width),
    .DIV   (Div)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .mode        (mode),
    .load        (load),
    .binary_in   (binary_in),
    .decoder_out (decoder_out),
    .index_out   (index_out),
    .wrap        (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: index as an integer, count of edges spent in the current scan period.
  int m_idx     = 0;
  int m_cnt     = 0;
  bit m_in_scan = 1'b0;
  bit m_en      = 1'b0;
  bit m_wrap    = 1'b0;

  task automatic model_reset();
    m_idx     = 0;
    m_cnt     = 0;
    m_in_scan = 1'b0;
    m_en      = 1'b0;
    m_wrap    = 1'b0;
  endtask

  task automatic model_edge();
    m_wrap = 1'b0;
    m_en   = enable;
    if (enable && mode && ScanEn) begin
      if (load) begin
        m_idx = int'(binary_in);
        m_cnt = 0;
      end else if (!m_in_scan) begin
        m_cnt = 0;
      end else begin
        m_cnt++;
        if (m_cnt == int'(Div)) begin
          m_cnt  = 0;
          m_wrap = (m_idx == N - 1);
          m_idx  = (m_idx + 1) % N;
        end
      end
      m_in_scan = 1'b1;
    end else begin
      m_in_scan = 1'b0;
      if (enable && load) m_idx = int'(binary_in);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [31:0] exp_dec;
    exp_dec = m_en ? (32'd1 << m_idx) : 32'd0;
    chk({tag, ".dec"}, 32'(decoder_out), exp_dec);
    chk({tag, ".idx"}, 32'(index_out), 32'(m_idx));
    chk({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
  endtask

  task automatic chk_out(input string tag, input logic [N-1:0] dec, input logic [Width-1:0] idx,
                         input logic wr);
    chk({tag, ".dec"}, 32'(decoder_out), 32'(dec));
    chk({tag, ".idx"}, 32'(index_out), 32'(idx));
    chk({tag, ".wrap"}, 32'(wrap), 32'(wr));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit en, input bit md, input bit ld, input logic [Width-1:0] bin);
    enable    = en;
    mode      = md;
    load      = ld;
    binary_in = bin;
  endtask

  typedef struct {
    bit               en;
    bit               md;
    bit               ld;
    logic [Width-1:0] bin;
    logic [N-1:0]     dec;
    logic [Width-1:0] idx;
    bit               wr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit en, bit md, bit ld, int bin, int dec, int idx, bit wr);
    vec_t v;
    v.en  = en;
    v.md  = md;
    v.ld  = ld;
    v.bin = Width'(bin);
    v.dec = N'(dec);
    v.idx = Width'(idx);
    v.wr  = wr;
    return v;
  endfunction

  initial begin
    logic [N-1:0]     exp_dec;
    logic [Width-1:0] exp_idx;

    // Direct sweep: each load shows one edge later.
    for (int i = 0; i < N; i++) vecs.push_back(mk(1, 0, 1, i, 1 << i, i, 0));
    // binary_in changes without load are ignored.
    vecs.push_back(mk(1, 0, 0, 7, 'h8000, 15, 0));
    vecs.push_back(mk(1, 0, 0, 2, 'h8000, 15, 0));
    // Enable gating around index 5; load while disabled is ignored.
    vecs.push_back(mk(1, 0, 1, 5, 'h0020, 5, 0));
    vecs.push_back(mk(0, 0, 0, 0, 'h0000, 5, 0));
    vecs.push_back(mk(0, 0, 1, 9, 'h0000, 5, 0));
    vecs.push_back(mk(1, 0, 0, 0, 'h0020, 5, 0));

    // Reset held with enable=1, mode=1.
    model_reset();
    rst_n = 1'b0;
    drive(1, 1, 0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", '0, '0, 1'b0);
    drive(0, 0, 0, '0);
    rst_n = 1'b1;
    tick();
    chk_out("rel_dis", '0, '0, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].md, vecs[i].ld, vecs[i].bin);
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].dec, vecs[i].idx, vecs[i].wr);
    end

    // Scan wrap: load 14 in direct, then switch to scan.
    drive(1, 0, 1, 4'd14);
    tick();
    chk_out("s_load", 16'h4000, 4'd14, 1'b0);
    drive(1, 1, 0, '0);
    tick();
    chk_out("s_entry", 16'h4000, 4'd14, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (!ScanEn)    exp_idx = 4'd14;
      else if (k < 4) exp_idx = 4'd14;
      else if (k < 8) exp_idx = 4'd15;
      else            exp_idx = 4'd0;
      exp_dec = N'(1) << exp_idx;
      chk_out($sformatf("s_step%0d", k), exp_dec, exp_idx, ScanEn && (k == 8));
    end
    // Three more edges put the prescaler on its terminal count; wrap must already be gone.
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out($sformatf("s_post%0d", k), ScanEn ? 16'h0001 : 16'h4000,
              ScanEn ? 4'd0 : 4'd14, 1'b0);
    end
    // Load on the terminal count: no increment, next step a full period later.
    drive(1, 1, 1, 4'd3);
    tick();
    chk_out("lvs_load", 16'h0008, 4'd3, 1'b0);
    drive(1, 1, 0, 4'd11);
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_idx = (ScanEn && k == 4) ? 4'd4 : 4'd3;
      chk_out($sformatf("lvs%0d", k), N'(1) << exp_idx, exp_idx, 1'b0);
    end

    // Async reset mid-scan at index 9.
    drive(1, 1, 1, 4'd9);
    tick();
    chk_out("ar_load", 16'h0200, 4'd9, 1'b0);
    drive(1, 1, 0, '0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("ar_async", '0, '0, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk_out("ar_restart", 16'h0001, 4'd0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_model($sformatf("ar_run%0d", k));
    end

    // Randomized run against the reference model.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0), Width'($urandom));
      tick();
      chk_model($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec_onehot_scan.md
# dec_onehot_scan

Parametrised, registered binary-to-one-hot decoder with enable, load strobe and an optional free-running scan mode. It is the clocked successor to the lab 4-bit combinational decoder. Typical use: digit/row select for multiplexed 7-segment and LED-matrix drivers, where the index is either loaded directly or stepped automatically at a divided rate.

## Interface

Parameters:
- WIDTH, 4, index width; output width is 2**WIDTH (legal 1..6)
- DIV, 4, scan step period in clock cycles (legal ≥1)

Ports:
- clk  in  1  system clock, rising-edge active
- rst_n  in  1  reset; asynchronous, active-low
- enable  in  1  1 = output active; 0 = output forced to zero, state frozen
- mode  in  1  0 = direct, 1 = scan
- load  in  1  single-cycle strobe: capture binary_in into index
- binary_in  in  WIDTH  index to load
- decoder_out  out  2**WIDTH  registered one-hot output, bit[index] set
- index_out  out  WIDTH  current registered index
- wrap  out  1  one-cycle pulse when scan index wraps from max to 0

## Operation

- Internal state: index reg (WIDTH), prescaler (ceil(log2 DIV), min 1 bit), FSM {IDLE, DIRECT, SCAN}.
- FSM, evaluated each edge: enable=0 → IDLE; enable=1 & mode=0 → DIRECT; enable=1 & mode=1 → SCAN.
- IDLE: decoder_out ← 0; index and prescaler held; wrap=0; load is ignored.
- DIRECT: load=1 → index ← binary_in; prescaler held at 0; no wrap.
- SCAN: prescaler counts 0..DIV-1. At DIV-1 it returns to 0 and index ← index+1, modulo 2**WIDTH. The step from 2**WIDTH-1 to 0 asserts wrap for that one cycle.
- Load beats step: load=1 in SCAN → index ← binary_in, prescaler ← 0, no step, no wrap, even if prescaler=DIV-1.
- Transition DIRECT→SCAN or IDLE→SCAN: prescaler cleared on entry; index retained. First step occurs DIV cycles after entry.
- DIV=1: index steps every cycle.
- decoder_out ← enable ? (1 << next_index) : 0. It is registered, so it is always exactly one-hot or all zero.
- index_out = index reg; it is valid in all states, including IDLE.

## Timing

- Reset (rst_n=0, asynchronous, immediate): decoder_out=0, index_out=0, wrap=0, prescaler=0, FSM=IDLE.
- First edge after release with enable=1: decoder_out=0x…0001, or the loaded index if load=1.
- Load latency: load and binary_in are sampled at edge k; index_out and decoder_out show the new value after edge k (one-cycle registered latency). No combinational path from inputs to outputs.
- binary_in changes without load have no effect.
- enable falling at edge k: decoder_out=0 after edge k. enable rising at edge k: decoder_out shows the held index after edge k.
- wrap is high for exactly the cycle following the wrapping edge. It coincides with decoder_out bit 0 becoming set.
- Reset asserted mid-scan: outputs clear without waiting for a clock edge; the scan restarts from index 0 after release.

## Configuration

- DEC_SCAN_MODE_EN defined: SCAN state, prescaler and wrap logic are built as described above.
- Undefined: the prescaler and SCAN state are not synthesised. mode is ignored and the block behaves as DIRECT whenever enable=1. wrap is tied to 0. Port list is unchanged.

## Test plan

- Reset: hold rst_n=0 with enable=1 and mode=1 → decoder_out=0x0000, index_out=0, wrap=0. Release with enable=0 → decoder_out stays 0x0000.
- Direct sweep (WIDTH=4): enable=1, mode=0, load binary_in=0..15 on successive cycles → decoder_out=0x0001…0x8000 one edge after each load. Changing binary_in with load=0 → no change.
- Enable gating: index=5, drop enable → decoder_out=0x0000 next edge, index_out=5. Raise enable → decoder_out=0x0020.
- Scan wrap (DIV=4, macro defined): load 14, then mode=1 → decoder_out 0x4000, then 0x8000 after 4 cycles, then 0x0001 after 4 more. wrap is a single-cycle pulse only at the 15→0 step.
- Load vs step: in SCAN with prescaler=3 (DIV-1), load binary_in=3 → index_out=3, no increment, next step to 4 occurs 4 cycles later.
- Async reset mid-scan at index 9 → outputs zero before the next clock edge. Rebuild without DEC_SCAN_MODE_EN and set mode=1 → index never self-increments, wrap stays 0.
